// File: rtl/d_cmp_iter.sv
// d_cmp_iter - iterative multi-mode operand comparator for the decode-stage
// branch path. Two WIDTH-bit operands are compared CHUNK bits per cycle,
// most significant chunk first, and the branch outcome is registered once
// the last needed chunk has been examined.
//
// Ports:
//   clk     clock, rising edge
//   reset   synchronous active-low reset
//   start   request; accepted in IDLE or DONE
//   mode    compare mode (latched on accept)
//   A, B    operands (latched on accept; B forced to 0 in zero modes)
//   busy    high while the compare is running
//   done    one-cycle pulse when the outcome is valid
//   result  branch condition outcome
//   eq      A == B
//   lt_s    A < B, signed
//   lt_u    A < B, unsigned
//   err     illegal mode on the last completed op
module d_cmp_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int EARLY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             eq,
  output logic             lt_s,
  output logic             lt_u,
  output logic             err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [3:0]       mode_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             decided_reg;
  logic             ltu_reg;

  logic             load;
  logic             finish;
  logic [CHUNK-1:0] cur_a, cur_b;
  logic             chunk_diff;
  logic             decided_now, ltu_now;
  logic             eq_next, lt_s_next, result_next, err_next;
  logic             zero_mode;

  // Zero modes (LEZ/GTZ/LTZ/GEZ) compare A against a literal zero.
  assign zero_mode = (mode >= 4'd6) && (mode <= 4'd9);

  // Select the chunk under examination.
  generate
    if (NCHUNK == 1) begin : g_single
      assign cur_a = a_reg;
      assign cur_b = b_reg;
    end else begin : g_multi
      logic [CHUNK-1:0] a_chunk [NCHUNK];
      logic [CHUNK-1:0] b_chunk [NCHUNK];
      for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
        assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
      end
      assign cur_a = a_chunk[idx_reg];
      assign cur_b = b_chunk[idx_reg];
    end
  endgenerate

  // The first differing chunk (from the MSB side) decides the unsigned order;
  // later chunks cannot change it.
  assign chunk_diff  = (cur_a != cur_b);
  assign decided_now = decided_reg | chunk_diff;
  assign ltu_now     = decided_reg ? ltu_reg : (chunk_diff && (cur_a < cur_b));

  assign finish = (state_reg == S_RUN) &&
                  ((idx_reg == '0) || ((EARLY != 0) && chunk_diff));

  // Signed order differs from unsigned only when the sign bits differ, in
  // which case the negative operand (sign bit set) is the smaller one.
  always_comb begin
    eq_next     = !decided_now;
    lt_s_next   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) ? a_reg[WIDTH-1] : ltu_now;
    result_next = 1'b0;
    err_next    = 1'b0;
    case (mode_reg)
      4'd0:         result_next = eq_next;
      4'd1:         result_next = !eq_next;
      4'd2, 4'd8:   result_next = lt_s_next;
      4'd3, 4'd9:   result_next = !lt_s_next;
      4'd4:         result_next = ltu_now;
      4'd5:         result_next = !ltu_now;
      4'd6, 4'd10:  result_next = lt_s_next | eq_next;
      4'd7, 4'd11:  result_next = !(lt_s_next | eq_next);
      default:      err_next    = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (finish) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      mode_reg    <= '0;
      idx_reg     <= IDX_LAST;
      decided_reg <= 1'b0;
      ltu_reg     <= 1'b0;
      result      <= 1'b0;
      eq          <= 1'b0;
      lt_s        <= 1'b0;
      lt_u        <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (load) begin
        a_reg       <= A;
        b_reg       <= zero_mode ? '0 : B;
        mode_reg    <= mode;
        idx_reg     <= IDX_LAST;
        decided_reg <= 1'b0;
        ltu_reg     <= 1'b0;
      end else if (state_reg == S_RUN) begin
        decided_reg <= decided_now;
        ltu_reg     <= ltu_now;
        idx_reg     <= idx_reg - IDX_W'(1);
      end
      if (finish) begin
        result <= result_next;
        eq     <= eq_next;
        lt_s   <= lt_s_next;
        lt_u   <= ltu_now;
        err    <= err_next;
      end
    end
  end

endmodule

// File: tb/tb_d_cmp_iter.sv
// Bench for d_cmp_iter. Three instances cover the interesting shapes:
//   0: WIDTH=32 CHUNK=8  EARLY=0   (4 chunks, fixed latency)
//   1: WIDTH=32 CHUNK=8  EARLY=1   (4 chunks, early finish)
//   2: WIDTH=32 CHUNK=32 EARLY=0   (single chunk)
// Expected outcomes come from plain integer comparisons of the operands.
module tb_d_cmp_iter;

  logic        clk;
  logic        reset;
  logic        start_v  [3];
  logic [3:0]  mode_v   [3];
  logic [31:0] a_v      [3];
  logic [31:0] b_v      [3];
  logic        busy_v   [3];
  logic        done_v   [3];
  logic        result_v [3];
  logic        eq_v     [3];
  logic        lt_s_v   [3];
  logic        lt_u_v   [3];
  logic        err_v    [3];

  int n_checks = 0;
  int n_pass   = 0;

  d_cmp_iter #(.WIDTH(32), .CHUNK(8), .EARLY(0)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode_v[0]),
    .A(a_v[0]), .B(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .result(result_v[0]), .eq(eq_v[0]), .lt_s(lt_s_v[0]), .lt_u(lt_u_v[0]),
    .err(err_v[0]));

  d_cmp_iter #(.WIDTH(32), .CHUNK(8), .EARLY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode_v[1]),
    .A(a_v[1]), .B(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .result(result_v[1]), .eq(eq_v[1]), .lt_s(lt_s_v[1]), .lt_u(lt_u_v[1]),
    .err(err_v[1]));

  d_cmp_iter #(.WIDTH(32), .CHUNK(32), .EARLY(0)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .mode(mode_v[2]),
    .A(a_v[2]), .B(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .result(result_v[2]), .eq(eq_v[2]), .lt_s(lt_s_v[2]), .lt_u(lt_u_v[2]),
    .err(err_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int chunk_of(input int d);
    return (d == 2) ? 32 : 8;
  endfunction

  function automatic bit early_of(input int d);
    return (d == 1);
  endfunction

  function automatic bit is_zero_mode(input logic [3:0] m);
    return (m >= 4'd6) && (m <= 4'd9);
  endfunction

  // Returns {err, result, eq, lt_s, lt_u}.
  function automatic logic [4:0] ref_model(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bb;
    logic        r, e;
    bb = is_zero_mode(m) ? 32'd0 : b;
    r  = 1'b0;
    e  = 1'b0;
    case (m)
      4'd0:  r = (a == bb);
      4'd1:  r = (a != bb);
      4'd2:  r = ($signed(a) <  $signed(bb));
      4'd3:  r = ($signed(a) >= $signed(bb));
      4'd4:  r = (a <  bb);
      4'd5:  r = (a >= bb);
      4'd6:  r = ($signed(a) <= 0);
      4'd7:  r = ($signed(a) >  0);
      4'd8:  r = ($signed(a) <  0);
      4'd9:  r = ($signed(a) >= 0);
      4'd10: r = ($signed(a) <= $signed(bb));
      4'd11: r = ($signed(a) >  $signed(bb));
      default: e = 1'b1;
    endcase
    return {e, r, (a == bb), ($signed(a) < $signed(bb)), (a < bb)};
  endfunction

  // Cycles from the accept edge to done being visible.
  function automatic int exp_lat(input int d, input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bb;
    logic [31:0] mask;
    int          ch, n;
    bb   = is_zero_mode(m) ? 32'd0 : b;
    ch   = chunk_of(d);
    n    = 32 / ch;
    mask = (ch == 32) ? 32'hFFFF_FFFF : ((32'd1 << ch) - 32'd1);
    if (!early_of(d)) return n;
    for (int j = 0; j < n; j++) begin
      int sh;
      sh = (n - 1 - j) * ch;
      if (((a >> sh) & mask) != ((bb >> sh) & mask)) return j + 1;
    end
    return n;
  endfunction

  task automatic idle(input int d, input int n);
    start_v[d] = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Issue one op; when poke is set, a stray start with other operands is
  // pulsed while the op is running.
  task automatic run_op(input int d, input logic [3:0] m, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    logic [4:0] e;
    int         lat, el;
    bit         seen;
    e  = ref_model(m, a, b);
    el = exp_lat(d, m, a, b);
    start_v[d] = 1'b1;
    mode_v[d]  = m;
    a_v[d]     = a;
    b_v[d]     = b;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    mode_v[d]  = 4'($urandom);
    a_v[d]     = $urandom;
    b_v[d]     = $urandom;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done_v[d]) seen = 1;
      else if (lat == 1) check("busy_after_accept", 32'(busy_v[d]), 32'd1);
      if (poke && !seen) start_v[d] = (lat == 1);
    end
    start_v[d] = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(el));
    check("busy_in_done", 32'(busy_v[d]), 32'd0);
    check("result", 32'(result_v[d]), 32'(e[3]));
    check("eq", 32'(eq_v[d]), 32'(e[2]));
    check("lt_s", 32'(lt_s_v[d]), 32'(e[1]));
    check("lt_u", 32'(lt_u_v[d]), 32'(e[0]));
    check("err", 32'(err_v[d]), 32'(e[4]));
    $display("op dut%0d mode=%0d A=%08h B=%08h lat=%0d result=%0b eq=%0b lt_s=%0b lt_u=%0b err=%0b",
             d, m, a, b, lat, result_v[d], eq_v[d], lt_s_v[d], lt_u_v[d], err_v[d]);
  endtask

  initial begin
    int done_cnt;
    logic [31:0] pool [5];
    pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0001; pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF;

    // Reset held with start asserted must not start anything.
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b1; mode_v[d] = 4'd0; a_v[d] = '0; b_v[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_busy", 32'(busy_v[d]), 32'd0);
      check("rst_done", 32'(done_v[d]), 32'd0);
      check("rst_result", 32'(result_v[d]), 32'd0);
      check("rst_eq", 32'(eq_v[d]), 32'd0);
      check("rst_lt", 32'({lt_s_v[d], lt_u_v[d]}), 32'd0);
      check("rst_err", 32'(err_v[d]), 32'd0);
      start_v[d] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_no_busy", 32'(busy_v[0]), 32'd0);
      check("idle_no_done", 32'(done_v[0]), 32'd0);
    end

    // Fixed-latency equality and ordering cases.
    run_op(0, 4'd0, 32'h1234_5678, 32'h1234_5678, 0);
    idle(0, 1);
    check("done_pulse", 32'(done_v[0]), 32'd0);
    check("result_hold", 32'(result_v[0]), 32'd1);
    run_op(0, 4'd1, 32'h1234_5678, 32'h1234_5678, 0);
    idle(0, 1);
    run_op(0, 4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    idle(0, 1);
    run_op(0, 4'd4, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    idle(0, 1);
    run_op(0, 4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    idle(0, 1);

    // Early finish.
    run_op(1, 4'd11, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    idle(1, 1);
    run_op(1, 4'd11, 32'h0000_0001, 32'h0000_0002, 0);
    idle(1, 1);

    // Zero modes ignore B.
    run_op(0, 4'd6, 32'h0000_0000, 32'hDEAD_BEEF, 0);
    idle(0, 1);
    run_op(0, 4'd7, 32'h8000_0000, 32'h0000_0000, 0);
    idle(0, 1);
    run_op(0, 4'd9, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    idle(0, 1);

    // Stray start mid-run, then back-to-back starts from DONE.
    run_op(0, 4'd4, 32'h0000_0001, 32'h0000_0002, 1);
    run_op(0, 4'd0, 32'h0000_0005, 32'h0000_0005, 0);
    run_op(0, 4'd1, 32'h0000_0005, 32'h0000_0006, 0);
    idle(0, 1);

    // Illegal mode and single-chunk latency.
    run_op(0, 4'hF, 32'h0000_0003, 32'h0000_0003, 0);
    idle(0, 1);
    run_op(2, 4'hF, 32'h0000_0003, 32'h0000_0004, 0);
    run_op(2, 4'd3, 32'h8000_0000, 32'h0000_0001, 0);
    idle(2, 1);

    // Reset in the middle of a run drops the op.
    run_op(0, 4'd0, 32'h0000_0007, 32'h0000_0007, 0);
    idle(0, 1);
    start_v[0] = 1'b1; mode_v[0] = 4'd1; a_v[0] = 32'h1; b_v[0] = 32'h2;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    check("midrun_busy", 32'(busy_v[0]), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst_busy", 32'(busy_v[0]), 32'd0);
    check("midrst_done", 32'(done_v[0]), 32'd0);
    check("midrst_eq", 32'(eq_v[0]), 32'd0);
    done_cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) done_cnt++;
    end
    check("midrst_no_activity", 32'(done_cnt), 32'd0);

    // Randomized ops on every instance.
    for (int d = 0; d < 3; d++) begin
      for (int t = 0; t < 40; t++) begin
        logic [3:0]  m;
        logic [31:0] a, b;
        int          kind;
        m    = 4'($urandom_range(0, 15));
        a    = $urandom;
        kind = $urandom_range(0, 3);
        case (kind)
          0: b = a;
          1: b = a ^ (32'd1 << $urandom_range(0, 31));
          2: b = $urandom;
          default: begin
            a = pool[$urandom_range(0, 4)];
            b = pool[$urandom_range(0, 4)];
          end
        endcase
        run_op(d, m, a, b, 0);
        idle(d, $urandom_range(0, 2));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
